// File: rtl/vga_rect_plotter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_rect_plotter
//  Description : Parametrised VGA rectangle plotter. Draws a filled box of
//                runtime width/height at a loaded (x,y) origin, one pixel per
//                clock in raster order, suppressing the write strobe for
//                pixels that fall off-screen. Also clears the whole screen
//                to black. Sits between user controls and the VGA adapter
//                write port.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Optional feature macro: RECT_OUTLINE_EN
//    defined   -> adds iOutline; when latched high only border pixels of the
//                 box are written (same cycle count as a filled box).
//    undefined -> iOutline is absent, boxes are always filled.
// ----------------------------------------------------------------------------
//  Ports
//    iClock     in   1         system clock, rising edge
//    iResetn    in   1         synchronous active-low reset
//    iLoadX     in   1         level: latch iXY_Coord as x origin
//    iPlotBox   in   1         level: latch y/colour/size, start box draw
//    iBlack     in   1         level: start full-screen clear (aborts draw)
//    iXY_Coord  in   X_W       coordinate bus (y uses [Y_W-1:0])
//    iColour    in   COLOUR_W  box colour
//    iBoxW      in   SIZE_W    box width minus 1
//    iBoxH      in   SIZE_W    box height minus 1
//    iOutline   in   1         outline mode (RECT_OUTLINE_EN only)
//    oX         out  X_W       pixel x
//    oY         out  Y_W       pixel y
//    oColour    out  COLOUR_W  pixel colour
//    oPlot      out  1         pixel write enable
//    oBusy      out  1         high whenever not idle
//    oDone      out  1         high from completion until next draw/clear
// ============================================================================
module vga_rect_plotter #(
    parameter int unsigned X_SCREEN_PIXELS = 160,
    parameter int unsigned Y_SCREEN_PIXELS = 120,
    parameter int unsigned X_W             = 8,
    parameter int unsigned Y_W             = 7,
    parameter int unsigned COLOUR_W        = 3,
    parameter int unsigned SIZE_W          = 4
) (
    input  logic                iClock,
    input  logic                iResetn,
    input  logic                iLoadX,
    input  logic                iPlotBox,
    input  logic                iBlack,
    input  logic [X_W-1:0]      iXY_Coord,
    input  logic [COLOUR_W-1:0] iColour,
    input  logic [SIZE_W-1:0]   iBoxW,
    input  logic [SIZE_W-1:0]   iBoxH,
`ifdef RECT_OUTLINE_EN
    input  logic                iOutline,
`endif
    output logic [X_W-1:0]      oX,
    output logic [Y_W-1:0]      oY,
    output logic [COLOUR_W-1:0] oColour,
    output logic                oPlot,
    output logic                oBusy,
    output logic                oDone
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LDX_WAIT   = 3'd1;
    localparam logic [2:0] S_PLOT_WAIT  = 3'd2;
    localparam logic [2:0] S_DRAW       = 3'd3;
    localparam logic [2:0] S_BLACK_WAIT = 3'd4;
    localparam logic [2:0] S_CLEAR      = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;

    // Last pixel of the screen-clear raster scan.
    localparam logic [X_W-1:0] c_X_LAST = X_W'(X_SCREEN_PIXELS - 1);
    localparam logic [Y_W-1:0] c_Y_LAST = Y_W'(Y_SCREEN_PIXELS - 1);

    // Screen limits, one bit wider to match the unclipped pixel sums.
    localparam logic [X_W:0]   c_X_LIMIT = (X_W + 1)'(X_SCREEN_PIXELS);
    localparam logic [Y_W:0]   c_Y_LIMIT = (Y_W + 1)'(Y_SCREEN_PIXELS);

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]          state_q,  state_d;
    logic [X_W-1:0]      x0_q,     x0_d;
    logic [Y_W-1:0]      y0_q,     y0_d;
    logic [COLOUR_W-1:0] colour_q, colour_d;
    logic [SIZE_W-1:0]   w_q,      w_d;
    logic [SIZE_W-1:0]   h_q,      h_d;
    // Offsets are sized for the full screen because the clear scan reuses
    // them; a box scan only ever uses the low SIZE_W bits.
    logic [X_W-1:0]      xoff_q,   xoff_d;
    logic [Y_W-1:0]      yoff_q,   yoff_d;
    logic                done_q,   done_d;
`ifdef RECT_OUTLINE_EN
    logic                outline_q, outline_d;
`endif

    // ------------------------------------------------------------------------
    // Pixel address and clipping
    // ------------------------------------------------------------------------
    logic [X_W-1:0] w_w_ext;
    logic [Y_W-1:0] w_h_ext;
    logic [X_W:0]   w_sum_x;
    logic [Y_W:0]   w_sum_y;
    logic           w_on_screen;
    logic           w_last_col_box;
    logic           w_last_row_box;
    logic           w_shape_ok;

    assign w_w_ext = X_W'(w_q);
    assign w_h_ext = Y_W'(h_q);

    // Sums carry one extra bit so a box hanging off the right/bottom edge
    // is detected rather than wrapping back onto the left/top of the screen.
    assign w_sum_x = {1'b0, x0_q} + {1'b0, xoff_q};
    assign w_sum_y = {1'b0, y0_q} + {1'b0, yoff_q};

    assign w_on_screen    = (w_sum_x < c_X_LIMIT) && (w_sum_y < c_Y_LIMIT);
    assign w_last_col_box = (xoff_q == w_w_ext);
    assign w_last_row_box = (yoff_q == w_h_ext);

`ifdef RECT_OUTLINE_EN
    // Outline mode keeps the full raster scan but only strobes the border.
    logic w_border;
    assign w_border   = (xoff_q == '0) || w_last_col_box ||
                        (yoff_q == '0) || w_last_row_box;
    assign w_shape_ok = !outline_q || w_border;
`else
    assign w_shape_ok = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        colour_d = colour_q;
        w_d      = w_q;
        h_d      = h_q;
        xoff_d   = xoff_q;
        yoff_d   = yoff_q;
        done_d   = done_q;
`ifdef RECT_OUTLINE_EN
        outline_d = outline_q;
`endif

        if (iBlack) begin
            // Clear request overrides everything, including a draw in
            // progress. Origin/colour/offsets are zeroed while waiting so the
            // clear starts at (0,0) in black as soon as the level drops.
            state_d  = S_BLACK_WAIT;
            x0_d     = '0;
            y0_d     = '0;
            colour_d = '0;
            xoff_d   = '0;
            yoff_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iLoadX) begin
                        x0_d    = iXY_Coord;
                        state_d = S_LDX_WAIT;
                    end else if (iPlotBox) begin
                        y0_d     = iXY_Coord[Y_W-1:0];
                        colour_d = iColour;
                        w_d      = iBoxW;
                        h_d      = iBoxH;
                        xoff_d   = '0;
                        yoff_d   = '0;
`ifdef RECT_OUTLINE_EN
                        outline_d = iOutline;
`endif
                        state_d  = S_PLOT_WAIT;
                    end
                end

                S_LDX_WAIT: begin
                    // Track the bus until the key is released.
                    x0_d = iXY_Coord;
                    if (!iLoadX) begin
                        state_d = S_IDLE;
                    end
                end

                S_PLOT_WAIT: begin
                    if (!iPlotBox) begin
                        done_d  = 1'b0;
                        state_d = S_DRAW;
                    end
                end

                S_DRAW: begin
                    if (w_last_col_box) begin
                        xoff_d = '0;
                        if (w_last_row_box) begin
                            state_d = S_DONE;
                        end else begin
                            yoff_d = yoff_q + 1'b1;
                        end
                    end else begin
                        xoff_d = xoff_q + 1'b1;
                    end
                end

                S_BLACK_WAIT: begin
                    // Only reached here once iBlack has been released.
                    done_d  = 1'b0;
                    state_d = S_CLEAR;
                end

                S_CLEAR: begin
                    if (xoff_q == c_X_LAST) begin
                        xoff_d = '0;
                        if (yoff_q == c_Y_LAST) begin
                            state_d = S_DONE;
                        end else begin
                            yoff_d = yoff_q + 1'b1;
                        end
                    end else begin
                        xoff_d = xoff_q + 1'b1;
                    end
                end

                S_DONE: begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge iClock) begin
        if (!iResetn) begin
            state_q  <= S_IDLE;
            x0_q     <= '0;
            y0_q     <= '0;
            colour_q <= '0;
            w_q      <= '0;
            h_q      <= '0;
            xoff_q   <= '0;
            yoff_q   <= '0;
            done_q   <= 1'b0;
`ifdef RECT_OUTLINE_EN
            outline_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            colour_q <= colour_d;
            w_q      <= w_d;
            h_q      <= h_d;
            xoff_q   <= xoff_d;
            yoff_q   <= yoff_d;
            done_q   <= done_d;
`ifdef RECT_OUTLINE_EN
            outline_q <= outline_d;
`endif
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign oX      = w_sum_x[X_W-1:0];
    assign oY      = w_sum_y[Y_W-1:0];
    assign oColour = colour_q;
    assign oPlot   = ((state_q == S_DRAW) && w_on_screen && w_shape_ok) ||
                     (state_q == S_CLEAR);
    assign oBusy   = (state_q != S_IDLE);
    assign oDone   = done_q;

endmodule
`default_nettype wire
